// File: rtl/filt_xfer_sequencer.sv
// filt_xfer_sequencer
//
// Control stage sitting in front of the address-calculation top. It accepts
// one transfer job (filter select, offset, filesize), enables the chosen
// filter, and alternates read bursts (RAM -> accelerator) with write bursts
// (accelerator -> RAM) by steering that filter's read/write pause lines. The
// job retires when the selected filter reports its write-done flag.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   start                    job request, only looked at while idle
//   filt_sel [1:0]           0=FFT, 1=FIR, 2=IIR, 3=illegal (err pulse)
//   offset_in, filesize_in   job base address and length
//   abort                    cancel the active job
//   accel_rd_ready           accelerator can take a read beat
//   accel_wr_valid           accelerator has a write beat
//   *_read_done/_write_done  done flags from the three address calculators
//   offset, filesize         latched job parameters
//   *_enable                 filter enables (one-hot or zero)
//   *_read_pause/_write_pause pause lines, 1 = paused
//   busy                     job in progress
//   job_done                 one-cycle pulse when the job retires
//   err                      one-cycle pulse (illegal select or stall timeout)
//
// Optional build macro: XFER_TIMEOUT_EN adds a stall watchdog that abandons
// the job after TIMEOUT_CYC consecutive cycles without a beat in RD/WR.

module filt_xfer_sequencer #(
    parameter int BURST_LEN   = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  filt_sel,
    input  logic [31:0] offset_in,
    input  logic [31:0] filesize_in,
    input  logic        abort,
    input  logic        accel_rd_ready,
    input  logic        accel_wr_valid,
    input  logic        fft_read_done,
    input  logic        fft_write_done,
    input  logic        fir_read_done,
    input  logic        fir_write_done,
    input  logic        iir_read_done,
    input  logic        iir_write_done,
    output logic [31:0] offset,
    output logic [31:0] filesize,
    output logic        fft_enable,
    output logic        fir_enable,
    output logic        iir_enable,
    output logic        fft_read_pause,
    output logic        fft_write_pause,
    output logic        fir_read_pause,
    output logic        fir_write_pause,
    output logic        iir_read_pause,
    output logic        iir_write_pause,
    output logic        busy,
    output logic        job_done,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, ARM, RD, WR, FIN} state_t;

    localparam logic [7:0] BURST_MAX  = 8'(BURST_LEN);
    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

    state_t      state, state_nx;
    logic [1:0]  sel;
    logic [7:0]  beat_cnt, beat_cnt_nx;
    logic        err_nx;
    logic        sel_rd_done, sel_wr_done;
    logic        rd_beat, wr_beat;
    logic        active;
    logic        accept;
    logic        timeout_hit;

    always_comb begin
        sel_rd_done = 1'b0;
        sel_wr_done = 1'b0;
        case (sel)
            2'd0:    begin sel_rd_done = fft_read_done; sel_wr_done = fft_write_done; end
            2'd1:    begin sel_rd_done = fir_read_done; sel_wr_done = fir_write_done; end
            2'd2:    begin sel_rd_done = iir_read_done; sel_wr_done = iir_write_done; end
            default: begin sel_rd_done = 1'b0;          sel_wr_done = 1'b0;           end
        endcase
    end

    // A beat is exactly a cycle in which the selected pause line is low.
    assign rd_beat = (state == RD) && accel_rd_ready;
    assign wr_beat = (state == WR) && accel_wr_valid;
    assign active  = (state == ARM) || (state == RD) || (state == WR);
    assign accept  = (state == IDLE) && start && (filt_sel != 2'd3);

`ifdef XFER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stalling;

    assign stalling    = ((state == RD) && !accel_rd_ready) || ((state == WR) && !accel_wr_valid);
    assign timeout_hit = stalling && (stall_cnt == STALL_W'(TIMEOUT_CYC - 1));

    // Counts consecutive beat-less cycles within one phase; any beat or any
    // state change restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!stalling || (state_nx != state)) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_param;

    assign timeout_hit          = 1'b0;
    assign unused_timeout_param = (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'd0;
            offset   <= 32'd0;
            filesize <= 32'd0;
            beat_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
            err      <= err_nx;
            if (accept) begin
                sel      <= filt_sel;
                offset   <= offset_in;
                filesize <= filesize_in;
            end
        end
    end

    // Burst sequencing. The beat counter saturates at BURST_LEN and is
    // cleared on every phase change; abort and timeout override everything.
    always_comb begin
        state_nx    = state;
        beat_cnt_nx = beat_cnt;
        err_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (filt_sel != 2'd3) state_nx = ARM;
                    else                  err_nx   = 1'b1;
                end
            end
            ARM: begin
                state_nx    = RD;
                beat_cnt_nx = 8'd0;
            end
            RD: begin
                if (rd_beat && (beat_cnt < BURST_MAX)) beat_cnt_nx = beat_cnt + 8'd1;
                if ((rd_beat && (beat_cnt == BURST_LAST)) || sel_rd_done) begin
                    state_nx    = WR;
                    beat_cnt_nx = 8'd0;
                end
            end
            WR: begin
                if (wr_beat && (beat_cnt < BURST_MAX)) beat_cnt_nx = beat_cnt + 8'd1;
                if (sel_wr_done) begin
                    state_nx = FIN;
                end else if (wr_beat && (beat_cnt == BURST_LAST)) begin
                    // Once reads are finished, keep draining in WR.
                    if (!sel_rd_done) state_nx = RD;
                    beat_cnt_nx = 8'd0;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (active && abort) begin
            state_nx    = IDLE;
            beat_cnt_nx = 8'd0;
            err_nx      = 1'b0;
        end else if (timeout_hit) begin
            state_nx    = IDLE;
            beat_cnt_nx = 8'd0;
            err_nx      = 1'b1;
        end
    end

    // Pause lines open only for the selected filter in the matching phase,
    // so both pauses of one filter can never be low together.
    always_comb begin
        fft_enable      = active && (sel == 2'd0);
        fir_enable      = active && (sel == 2'd1);
        iir_enable      = active && (sel == 2'd2);
        fft_read_pause  = !(rd_beat && (sel == 2'd0));
        fir_read_pause  = !(rd_beat && (sel == 2'd1));
        iir_read_pause  = !(rd_beat && (sel == 2'd2));
        fft_write_pause = !(wr_beat && (sel == 2'd0));
        fir_write_pause = !(wr_beat && (sel == 2'd1));
        iir_write_pause = !(wr_beat && (sel == 2'd2));
        busy            = (state != IDLE);
        job_done        = (state == FIN);
    end

endmodule

// File: tb/tb_filt_xfer_sequencer.sv
// Self-checking bench for filt_xfer_sequencer. The bench plays the role of
// the accelerator and the address calculators: it counts read and write
// beats, raises the selected filter's done flags once filesize beats have
// moved, and compares the observed beat order against the burst pattern
// derived from the burst length and filesize.

module tb_filt_xfer_sequencer;

    localparam int BURST = 16;
    localparam int TOUT  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  filt_sel;
    logic [31:0] offset_in;
    logic [31:0] filesize_in;
    logic        abort;
    logic        accel_rd_ready;
    logic        accel_wr_valid;
    logic [2:0]  rd_done_v;
    logic [2:0]  wr_done_v;
    logic [31:0] offset;
    logic [31:0] filesize;
    logic        fft_enable, fir_enable, iir_enable;
    logic        fft_read_pause, fft_write_pause;
    logic        fir_read_pause, fir_write_pause;
    logic        iir_read_pause, iir_write_pause;
    logic        busy, job_done, err;

    logic [2:0]  en_v, rp_v, wp_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign en_v = {iir_enable, fir_enable, fft_enable};
    assign rp_v = {iir_read_pause, fir_read_pause, fft_read_pause};
    assign wp_v = {iir_write_pause, fir_write_pause, fft_write_pause};

    filt_xfer_sequencer #(
        .BURST_LEN   (BURST),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .filt_sel        (filt_sel),
        .offset_in       (offset_in),
        .filesize_in     (filesize_in),
        .abort           (abort),
        .accel_rd_ready  (accel_rd_ready),
        .accel_wr_valid  (accel_wr_valid),
        .fft_read_done   (rd_done_v[0]),
        .fft_write_done  (wr_done_v[0]),
        .fir_read_done   (rd_done_v[1]),
        .fir_write_done  (wr_done_v[1]),
        .iir_read_done   (rd_done_v[2]),
        .iir_write_done  (wr_done_v[2]),
        .offset          (offset),
        .filesize        (filesize),
        .fft_enable      (fft_enable),
        .fir_enable      (fir_enable),
        .iir_enable      (iir_enable),
        .fft_read_pause  (fft_read_pause),
        .fft_write_pause (fft_write_pause),
        .fir_read_pause  (fir_read_pause),
        .fir_write_pause (fir_write_pause),
        .iir_read_pause  (iir_read_pause),
        .iir_write_pause (iir_write_pause),
        .busy            (busy),
        .job_done        (job_done),
        .err             (err)
    );

    task automatic clear_inputs();
        start          = 1'b0;
        filt_sel       = 2'd0;
        offset_in      = 32'd0;
        filesize_in    = 32'd0;
        abort          = 1'b0;
        accel_rd_ready = 1'b0;
        accel_wr_valid = 1'b0;
        rd_done_v      = 3'b000;
        wr_done_v      = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({en_v, rp_v, wp_v, busy, job_done, err} !== 12'b000_111_111_000) begin
            n_bad++;
            $display("[TB] FAIL reset_outputs got=%b want=%b", {en_v, rp_v, wp_v, busy, job_done, err}, 12'b000_111_111_000);
        end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({en_v, rp_v, wp_v, busy, job_done, err, offset, filesize} !== {12'b000_111_111_000, 64'd0}) begin
                n_bad++;
                $display("[TB] FAIL idle_after_reset cycle=%0d got=%b off=%h fs=%h want=000111111000 off=0 fs=0",
                         i, {en_v, rp_v, wp_v, busy, job_done, err}, offset, filesize);
            end
        end
    endtask

    task automatic test_transfer(input logic [1:0] sel, input logic [31:0] off, input int fs, input bit rnd);
        byte exp_q[$];
        byte obs_q[$];
        int  reads = 0;
        int  writes = 0;
        int  cycle = 0;
        int  fin_cycle = -1;
        int  chunk;
        int  first_bad;
        bit  ok;
        logic [2:0] exp_en;

        // Expected order: each read burst of min(BURST, remaining) is
        // followed by a write burst of the same length.
        for (int r = 0; r < fs; r += chunk) begin
            chunk = (fs - r < BURST) ? fs - r : BURST;
            for (int k = 0; k < chunk; k++) exp_q.push_back(8'h52);
            for (int k = 0; k < chunk; k++) exp_q.push_back(8'h57);
        end

        while ((fin_cycle < 0 || cycle <= fin_cycle) && cycle < 3000) begin
            @(negedge clk);
            if (cycle == 0) begin
                start       = 1'b1;
                filt_sel    = sel;
                offset_in   = off;
                filesize_in = 32'(fs);
            end else begin
                start       = 1'($urandom_range(0, 1));
                filt_sel    = 2'($urandom_range(0, 3));
                offset_in   = $urandom;
                filesize_in = $urandom;
            end
            accel_rd_ready = (reads < fs) && (!rnd || ($urandom_range(0, 3) != 0));
            accel_wr_valid = (writes < reads) && (!rnd || ($urandom_range(0, 1) != 0));
            rd_done_v      = 3'b000;
            wr_done_v      = 3'b000;
            rd_done_v[sel] = (reads >= fs);
            wr_done_v[sel] = (writes >= fs);
            if (writes >= fs && fin_cycle < 0) fin_cycle = cycle + 1;
            #1;

            n_cmp++;
            if (busy !== (cycle != 0)) begin
                n_bad++;
                $display("[TB] FAIL busy cycle=%0d got=%b want=%b", cycle, busy, (cycle != 0));
            end
            n_cmp++;
            if (job_done !== (cycle == fin_cycle)) begin
                n_bad++;
                $display("[TB] FAIL job_done cycle=%0d got=%b want=%b", cycle, job_done, (cycle == fin_cycle));
            end
            exp_en = (cycle >= 1 && cycle != fin_cycle) ? (3'b001 << sel) : 3'b000;
            n_cmp++;
            if (en_v !== exp_en) begin
                n_bad++;
                $display("[TB] FAIL enables cycle=%0d got=%b want=%b", cycle, en_v, exp_en);
            end

            ok = 1'b1;
            for (int f = 0; f < 3; f++) begin
                if (!rp_v[f] && !wp_v[f]) ok = 1'b0;
                if (f != int'(sel) && (!rp_v[f] || !wp_v[f])) ok = 1'b0;
            end
            if (!accel_rd_ready && !rp_v[sel]) ok = 1'b0;
            if (!accel_wr_valid && !wp_v[sel]) ok = 1'b0;
            if (cycle == fin_cycle && (rp_v != 3'b111 || wp_v != 3'b111)) ok = 1'b0;
            n_cmp++;
            if (ok !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL pause_rules cycle=%0d got rp=%b wp=%b rdy=%b vld=%b want legal pauses",
                         cycle, rp_v, wp_v, accel_rd_ready, accel_wr_valid);
            end

            if (cycle >= 1) begin
                n_cmp++;
                if (offset !== off || filesize !== 32'(fs)) begin
                    n_bad++;
                    $display("[TB] FAIL latched_params cycle=%0d got off=%h fs=%0d want off=%h fs=%0d",
                             cycle, offset, filesize, off, fs);
                end
            end
            n_cmp++;
            if (err !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL err_in_job cycle=%0d got=%b want=0", cycle, err);
            end

            if (!rp_v[sel]) begin obs_q.push_back(8'h52); reads++;  end
            if (!wp_v[sel]) begin obs_q.push_back(8'h57); writes++; end
            cycle++;
        end

        n_cmp++;
        if (fin_cycle < 0 || cycle > fin_cycle + 1 || cycle >= 3000) begin
            n_bad++;
            $display("[TB] FAIL job_timeout got cycles=%0d want completion", cycle);
        end
        first_bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (first_bad < 0 && obs_q[i] != exp_q[i]) first_bad = i;
        n_cmp++;
        if (obs_q.size() != exp_q.size() || first_bad >= 0) begin
            n_bad++;
            $display("[TB] FAIL beat_order sel=%0d fs=%0d got len=%0d first_diff=%0d want len=%0d",
                     sel, fs, obs_q.size(), first_bad, exp_q.size());
        end

        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if ({busy, job_done, en_v, rp_v, wp_v} !== 11'b00_000_111_111) begin
            n_bad++;
            $display("[TB] FAIL after_job got=%b want=00000111111", {busy, job_done, en_v, rp_v, wp_v});
        end
    endtask

    task automatic test_illegal_sel();
        logic [2:0] exp_err;
        exp_err = 3'b010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            if (i == 0) begin
                start    = 1'b1;
                filt_sel = 2'd3;
            end
            #1;
            n_cmp++;
            if (err !== exp_err[i] || busy !== 1'b0 || en_v !== 3'b000) begin
                n_bad++;
                $display("[TB] FAIL illegal_sel cycle=%0d got err=%b busy=%b en=%b want err=%b busy=0 en=000",
                         i, err, busy, en_v, exp_err[i]);
            end
        end
    endtask

    task automatic test_abort();
        int  reads = 0;
        bit  hit = 1'b0;
        logic [31:0] off2;
        off2 = $urandom;

        @(negedge clk);
        clear_inputs();
        start       = 1'b1;
        filt_sel    = 2'd0;
        offset_in   = $urandom;
        filesize_in = 32'd100;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            start          = 1'b0;
            accel_rd_ready = 1'b1;
            abort          = (reads == 4);
            rd_done_v[0]   = (reads == 4);
            #1;
            n_cmp++;
            if (job_done !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL abort_no_done cycle=%0d got=%b want=0", c, job_done);
            end
            if (!rp_v[0]) reads++;
            hit = abort;
        end
        n_cmp++;
        if (reads !== 5) begin
            n_bad++;
            $display("[TB] FAIL abort_beat got reads=%0d want 5", reads);
        end

        @(negedge clk);
        clear_inputs();
        start       = 1'b1;
        filt_sel    = 2'd2;
        offset_in   = off2;
        filesize_in = 32'd7;
        #1;
        n_cmp++;
        if ({en_v, rp_v, wp_v, busy, job_done} !== 11'b000_111_111_00) begin
            n_bad++;
            $display("[TB] FAIL abort_next_cycle got=%b want=00011111100", {en_v, rp_v, wp_v, busy, job_done});
        end

        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b1 || en_v !== 3'b100 || offset !== off2) begin
            n_bad++;
            $display("[TB] FAIL restart_after_abort got busy=%b en=%b off=%h want busy=1 en=100 off=%h",
                     busy, en_v, offset, off2);
        end
        abort = 1'b1;

        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if ({busy, job_done, en_v} !== 5'b00_000) begin
            n_bad++;
            $display("[TB] FAIL abort_in_arm got=%b want=00000", {busy, job_done, en_v});
        end
    endtask

`ifdef XFER_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        clear_inputs();
        start       = 1'b1;
        filt_sel    = 2'd0;
        filesize_in = 32'd50;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n_cmp++;
            if (err !== (c == TOUT + 2) || busy !== (c < TOUT + 2) || job_done !== 1'b0) begin
                n_bad++;
                $display("[TB] FAIL timeout cycle=%0d got err=%b busy=%b done=%b want err=%b busy=%b done=0",
                         c, err, busy, job_done, (c == TOUT + 2), (c < TOUT + 2));
            end
        end
    endtask
`else
    task automatic test_no_timeout();
        @(negedge clk);
        clear_inputs();
        start       = 1'b1;
        filt_sel    = 2'd1;
        filesize_in = 32'd50;
        for (int c = 1; c <= 3 * TOUT; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            n_cmp++;
            if (err !== 1'b0 || busy !== 1'b1) begin
                n_bad++;
                $display("[TB] FAIL long_stall cycle=%0d got err=%b busy=%b want err=0 busy=1", c, err, busy);
            end
        end
        abort = 1'b1;
        @(negedge clk);
        clear_inputs();
    endtask
`endif

    task automatic test_midjob_reset();
        @(negedge clk);
        clear_inputs();
        start       = 1'b1;
        filt_sel    = 2'd1;
        offset_in   = 32'hDEAD_BEEF;
        filesize_in = 32'd30;
        repeat (6) begin
            @(negedge clk);
            start          = 1'b0;
            accel_rd_ready = 1'b1;
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({en_v, rp_v, wp_v, busy, job_done, err, offset, filesize} !== {12'b000_111_111_000, 64'd0}) begin
            n_bad++;
            $display("[TB] FAIL midjob_reset got=%b off=%h fs=%h want=000111111000 off=0 fs=0",
                     {en_v, rp_v, wp_v, busy, job_done, err}, offset, filesize);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_transfer(2'd1, 32'h0000_0100, 40, 1'b0);
        test_transfer(2'd2, $urandom, 37, 1'b1);
        test_illegal_sel();
        test_abort();
        for (int j = 0; j < 4; j++)
            test_transfer(2'($urandom_range(0, 2)), $urandom, $urandom_range(1, 70), 1'b1);
`ifdef XFER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_midjob_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
